// File: rtl/qarma_loader_pkg.sv
// Shared types and constants for the QARMA operand loader: FSM states,
// per-operand word bases within the 20-word load sequence, and block width.
package qarma_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam int BLOCK_W = 128;

  localparam logic [4:0] P_BASE    = 5'd0;
  localparam logic [4:0] T0_BASE   = 5'd4;
  localparam logic [4:0] T1_BASE   = 5'd8;
  localparam logic [4:0] K0_BASE   = 5'd12;
  localparam logic [4:0] K1_BASE   = 5'd16;
  localparam logic [4:0] LAST_WORD = 5'd19;

  // True when word index idx belongs to the four-word operand starting at base.
  function automatic logic in_operand(input logic [4:0] idx, input logic [4:0] base);
    return (idx >= base) && (idx <= base + 5'd3);
  endfunction

endpackage

// File: rtl/qarma_loader_if.sv
// Word stream in, held operand set out: the loader is the slave, the
// upstream source / cipher-side consumer pair is the master.
interface qarma_loader_if;
  import qarma_loader_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [31:0]        s_data;
  logic               s_enc;
  logic               s_abort;
  logic               enc;
  logic [BLOCK_W-1:0] P;
  logic [BLOCK_W-1:0] T0;
  logic [BLOCK_W-1:0] T1;
  logic [BLOCK_W-1:0] K0;
  logic [BLOCK_W-1:0] K1;
  logic               op_valid;
  logic               op_ack;

  modport master (
    output s_valid, s_data, s_enc, s_abort, op_ack,
    input  s_ready, enc, P, T0, T1, K0, K1, op_valid
  );

  modport slave (
    input  s_valid, s_data, s_enc, s_abort, op_ack,
    output s_ready, enc, P, T0, T1, K0, K1, op_valid
  );

endinterface

// File: rtl/qarma_word_shifter.sv
// One 128-bit operand register filled one 32-bit word at a time; word 0 of
// the operand lands in the most significant slot.
module qarma_word_shifter
  import qarma_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [1:0]         idx,
  input  logic [WORD_W-1:0]  din,
  output logic [BLOCK_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      case (idx)
        2'd0:    q[BLOCK_W-1 -: WORD_W]            <= din;
        2'd1:    q[BLOCK_W-1-WORD_W -: WORD_W]     <= din;
        2'd2:    q[BLOCK_W-1-2*WORD_W -: WORD_W]   <= din;
        default: q[WORD_W-1:0]                     <= din;
      endcase
    end
  end

endmodule

// File: rtl/qarma_loader.sv
// Collects 20 words into the P/T0/T1/K0/K1 operand set, waits for the cipher
// core's combinational path to settle, then holds the set until acknowledged.
module qarma_loader
  import qarma_loader_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  qarma_loader_if.slave  bus
);

  state_t     state;
  logic [4:0] word_cnt;
  logic [3:0] settle_cnt;
  logic       enc_q;
  logic       s_ready_q;
  logic       op_valid_q;
  logic       accept;

  // Abort wins over a coincident word, so it masks acceptance outright.
  assign accept = s_ready_q && bus.s_valid && !bus.s_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      word_cnt   <= '0;
      settle_cnt <= '0;
      enc_q      <= 1'b0;
      s_ready_q  <= 1'b1;
      op_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.s_abort) begin
            word_cnt <= '0;
          end else if (accept) begin
            if (word_cnt == P_BASE) begin
              enc_q <= bus.s_enc;
            end
            if (word_cnt == LAST_WORD) begin
              word_cnt   <= '0;
              settle_cnt <= 4'(SETTLE_CYCLES);
              s_ready_q  <= 1'b0;
              state      <= ST_SETTLE;
            end else begin
              word_cnt <= word_cnt + 5'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            op_valid_q <= 1'b1;
            state      <= ST_PRESENT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_PRESENT: begin
          if (bus.op_ack) begin
            op_valid_q <= 1'b0;
            s_ready_q  <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        default: begin
          state      <= ST_LOAD;
          word_cnt   <= '0;
          s_ready_q  <= 1'b1;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.op_valid = op_valid_q;
  assign bus.enc      = enc_q;

  qarma_word_shifter #(.WORD_W(WORD_W)) u_p (
    .clk(clk), .rst(rst), .we(accept && in_operand(word_cnt, P_BASE)),
    .idx(word_cnt[1:0]), .din(bus.s_data), .q(bus.P)
  );

  qarma_word_shifter #(.WORD_W(WORD_W)) u_t0 (
    .clk(clk), .rst(rst), .we(accept && in_operand(word_cnt, T0_BASE)),
    .idx(word_cnt[1:0]), .din(bus.s_data), .q(bus.T0)
  );

  qarma_word_shifter #(.WORD_W(WORD_W)) u_t1 (
    .clk(clk), .rst(rst), .we(accept && in_operand(word_cnt, T1_BASE)),
    .idx(word_cnt[1:0]), .din(bus.s_data), .q(bus.T1)
  );

  qarma_word_shifter #(.WORD_W(WORD_W)) u_k0 (
    .clk(clk), .rst(rst), .we(accept && in_operand(word_cnt, K0_BASE)),
    .idx(word_cnt[1:0]), .din(bus.s_data), .q(bus.K0)
  );

  qarma_word_shifter #(.WORD_W(WORD_W)) u_k1 (
    .clk(clk), .rst(rst), .we(accept && in_operand(word_cnt, K1_BASE)),
    .idx(word_cnt[1:0]), .din(bus.s_data), .q(bus.K1)
  );

endmodule

// File: tb/tb_qarma_loader.sv
// Drives two loaders (settle 4 and settle 0) with identical stimulus and
// compares both against a timestamp-based model of the load/settle/present rules.
module tb_qarma_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_enc;
  logic        s_abort;
  logic        op_ack;
  logic [31:0] s_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: index 0 is the SETTLE_CYCLES=4 loader, index 1 the SETTLE_CYCLES=0 one.
  logic [31:0] m_op [2][20];
  logic        m_enc [2];
  int          m_words [2];
  bit          m_full [2];
  int          m_done [2];

  localparam logic [127:0] P_REF = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  qarma_loader_if bus4();
  qarma_loader_if bus0();

  assign bus4.s_valid = s_valid;
  assign bus4.s_data  = s_data;
  assign bus4.s_enc   = s_enc;
  assign bus4.s_abort = s_abort;
  assign bus4.op_ack  = op_ack;
  assign bus0.s_valid = s_valid;
  assign bus0.s_data  = s_data;
  assign bus0.s_enc   = s_enc;
  assign bus0.s_abort = s_abort;
  assign bus0.op_ack  = op_ack;

  qarma_loader #(.WORD_W(32), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  qarma_loader #(.WORD_W(32), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  function automatic int settle_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  // A completed set is presented from settle+1 edges after its last word.
  function automatic bit m_valid(input int d);
    return m_full[d] && ((cyc - m_done[d]) >= settle_of(d) + 1);
  endfunction

  function automatic logic [127:0] m_operand(input int d, input int base);
    return {m_op[d][base], m_op[d][base+1], m_op[d][base+2], m_op[d][base+3]};
  endfunction

  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      bit pv;
      pv = m_valid(d);
      if (rst) begin
        for (int w = 0; w < 20; w++) m_op[d][w] = '0;
        m_enc[d]   = 1'b0;
        m_words[d] = 0;
        m_full[d]  = 1'b0;
      end else if (!m_full[d]) begin
        if (s_abort) begin
          m_words[d] = 0;
        end else if (s_valid) begin
          m_op[d][m_words[d]] = s_data;
          if (m_words[d] == 0) m_enc[d] = s_enc;
          m_words[d]++;
          if (m_words[d] == 20) begin
            m_full[d]  = 1'b1;
            m_done[d]  = cyc + 1;
            m_words[d] = 0;
          end
        end
      end else if (op_ack && pv) begin
        m_full[d] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic check1(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input int d, input string nm, input logic rdy, input logic vld,
                          input logic e, input logic [127:0] p, input logic [127:0] t0,
                          input logic [127:0] t1, input logic [127:0] k0,
                          input logic [127:0] k1);
    check1({nm, ".s_ready"},  rdy, !m_full[d]);
    check1({nm, ".op_valid"}, vld, m_valid(d));
    check1({nm, ".enc"},      e,   m_enc[d]);
    check1({nm, ".P"},        p,   m_operand(d, 0));
    check1({nm, ".T0"},       t0,  m_operand(d, 4));
    check1({nm, ".T1"},       t1,  m_operand(d, 8));
    check1({nm, ".K0"},       k0,  m_operand(d, 12));
    check1({nm, ".K1"},       k1,  m_operand(d, 16));
  endtask

  task automatic checkOutput();
    checkDut(0, "s4", bus4.s_ready, bus4.op_valid, bus4.enc,
             bus4.P, bus4.T0, bus4.T1, bus4.K0, bus4.K1);
    checkDut(1, "s0", bus0.s_ready, bus0.op_valid, bus0.enc,
             bus0.P, bus0.T0, bus0.T1, bus0.K0, bus0.K1);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] data,
                               input logic e, input logic a, input logic ack);
    rst     = r;
    s_valid = v;
    s_data  = data;
    s_enc   = e;
    s_abort = a;
    op_ack  = ack;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom, 1'($urandom), 1'b0, 1'b0);
  endtask

  // Only word 0 carries the direction; later words get a random s_enc that must be ignored.
  task automatic streamSet(input logic encv, input bit fixed_p);
    logic [31:0] pw [4];
    logic [31:0] w;
    pw = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    for (int i = 0; i < 20; i++) begin
      w = fixed_p ? ((i < 4) ? pw[i] : 32'h0) : $urandom;
      applyStimulus(1'b0, 1'b1, w, (i == 0) ? encv : 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic waitBothPresent(input string tag);
    int k;
    k = 0;
    while (!(bus4.op_valid === 1'b1 && bus0.op_valid === 1'b1) && k < 40) begin
      idle(1);
      k++;
    end
    check1(tag, bus4.op_valid && bus0.op_valid, 1'b1);
  endtask

  initial begin
    int rise4;
    int rise0;
    rst = 1'b1; s_valid = 1'b0; s_enc = 1'b0; s_abort = 1'b0; op_ack = 1'b0; s_data = '0;

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check1("reset_ready", bus4.s_ready, 1'b1);
    check1("reset_valid", bus4.op_valid, 1'b0);

    // Basic load with fixed P and measured settle latency for both settings.
    streamSet(1'b1, 1'b1);
    rise4 = -1;
    rise0 = -1;
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      if (bus4.op_valid === 1'b1 && rise4 < 0) rise4 = k;
      if (bus0.op_valid === 1'b1 && rise0 < 0) rise0 = k;
      check1("settle_ready_low", bus4.s_ready, 1'b0);
    end
    check1("rise_settle4", rise4, 5);
    check1("rise_settle0", rise0, 1);
    check1("load_P_s4", bus4.P, P_REF);
    check1("load_P_s0", bus0.P, P_REF);

    // Hold in PRESENT without ack, then release.
    idle(10);
    check1("held_P", bus4.P, P_REF);
    check1("held_K1", bus4.K1, 128'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check1("release_ready", bus4.s_ready, 1'b1);
    check1("release_enc", bus4.enc, 1'b1);
    check1("release_valid", bus0.op_valid, 1'b0);

    // Abort after 7 words, with a coincident word that must be dropped.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    check1("abort_drop_T0lo", bus4.T0[31:0], 32'h0);
    streamSet(1'($urandom_range(0, 1)), 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    waitBothPresent("abort_present");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Random traffic; the two loaders drift apart and the model tracks each.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 3) == 0));
    end

    // Reset while presenting, then reset mid-settle.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    streamSet(1'b1, 1'b0);
    waitBothPresent("prereset_present");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check1("rst_present_valid", bus4.op_valid, 1'b0);
    check1("rst_present_P", bus4.P, 128'h0);
    check1("rst_present_K1", bus4.K1, 128'h0);
    check1("rst_present_ready", bus4.s_ready, 1'b1);
    streamSet(1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(8);
    check1("rst_settle_no_valid", bus4.op_valid, 1'b0);

    // Stray ack in LOAD, decrypt set, zero-settle latency.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    streamSet(1'b0, 1'b0);
    idle(1);
    check1("zero_settle_valid", bus0.op_valid, 1'b1);
    check1("zero_settle_enc", bus0.enc, 1'b0);
    waitBothPresent("final_present");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qarma_loader.md
QARMA_LOADER -- requirements
Module: qarma_loader

Interface
REQ-001 Parameter: WORD_W, 32, input word width; only value 32 is supported.
REQ-002 Parameter: SETTLE_CYCLES, 4, number of idle cycles between load completion and op_valid (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_ready  output  1  loader accepts a word this cycle.
REQ-007 s_data  input  32  operand word.
REQ-008 s_enc  input  1  direction flag, sampled with word 0 (1 = encrypt, 0 = decrypt).
REQ-009 s_abort  input  1  discard a partially loaded operand set.
REQ-010 enc  output  1  held direction flag to the cipher core.
REQ-011 P, T0, T1, K0, K1  output  128 each  held operands to the cipher core.
REQ-012 op_valid  output  1  operands stable and the core output is settled.
REQ-013 op_ack  input  1  consumer has captured C; releases the operand set.

Function
REQ-014 The loader SHALL implement a three-state FSM: LOAD, SETTLE and PRESENT.
REQ-015 In LOAD, s_ready SHALL be 1. In SETTLE and PRESENT, s_ready SHALL be 0.
REQ-016 A word SHALL be accepted only on a cycle where s_valid and s_ready are both 1.
REQ-017 A 5-bit word counter (0..19) SHALL track accepted words in this order: 0-3 P, 4-7 T0, 8-11 T1, 12-15 K0, 16-19 K1.
  - Within each operand, the first word SHALL land in bits [127:96] and the fourth word in bits [31:0].
REQ-018 s_enc SHALL be latched into enc only when word 0 is accepted.
REQ-019 On acceptance of word 19, the FSM SHALL:
  - move to SETTLE;
  - clear the word counter;
  - load the settle counter with SETTLE_CYCLES.
REQ-020 Settle counter behaviour:
  - In SETTLE, the counter SHALL decrement each cycle.
  - When it is 0 at the start of a SETTLE cycle, the FSM SHALL move to PRESENT on the next edge.
  - With SETTLE_CYCLES=0, SETTLE therefore lasts exactly one cycle.
REQ-021 op_valid SHALL be 1 exactly while in PRESENT. It SHALL first be 1 SETTLE_CYCLES+1 cycles after the edge that accepted word 19.
REQ-022 In PRESENT, op_ack=1 SHALL move the FSM to LOAD on the same edge. s_ready SHALL be 1 on the following cycle.
REQ-023 op_ack SHALL be ignored in LOAD and SETTLE.
REQ-024 Operand and enc registers SHALL change only on word acceptance. They SHALL be bit-stable throughout SETTLE and PRESENT.
REQ-025 s_abort in LOAD SHALL clear the word counter; operand registers are left unchanged.
  - If s_abort and a word acceptance coincide, abort SHALL win and the word SHALL be dropped.
  - s_abort SHALL be ignored in SETTLE and PRESENT.
REQ-026 The loader SHALL raise no error on s_valid while s_ready=0. The word is simply not taken, and upstream must hold it.

Reset
REQ-027 On rst=1 at an edge, the FSM SHALL enter LOAD, clear both counters, and zero P, T0, T1, K0, K1 and enc.
REQ-028 After reset, op_valid SHALL be 0 and s_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-load, mid-SETTLE or in PRESENT SHALL discard all progress. No stale op_valid pulse SHALL follow.

Structure
REQ-030 A shared package SHALL hold:
  - the FSM state enum;
  - the operand word-index constants (P_BASE=0, T0_BASE=4, T1_BASE=8, K0_BASE=12, K1_BASE=16, LAST_WORD=19);
  - the 128-bit block width constant.
REQ-031 One sub-module, qarma_word_shifter, SHALL implement the 128-bit register written 32 bits at a time by index. It SHALL be instantiated five times.
REQ-032 The loader outputs SHALL connect directly to the cipher core's enc, P, T0, T1, K0 and K1 inputs. SETTLE_CYCLES covers the core's multicycle combinational path.

Verification
REQ-033 Basic load and settle:
  - Stimulus: after reset, stream 20 words with s_valid held at 1: P=0x00112233_44556677_8899AABB_CCDDEEFF, all other words 0, s_enc=1.
  - Required response: P output matches; op_valid rises exactly 5 cycles after word 19 is accepted; s_ready=0 from then until op_ack.
REQ-034 Backpressure and release:
  - Stimulus: hold op_ack=0 for 10 cycles in PRESENT, then pulse op_ack=1.
  - Required response: operands stay constant for all 10 cycles; s_ready=1 on the next cycle; enc=1 retained.
REQ-035 Abort:
  - Stimulus: accept 7 words, assert s_abort together with an s_valid word, then stream 20 fresh words.
  - Required response: the fresh set lands at indices 0..19; the aborted word is not written.
REQ-036 Reset during PRESENT:
  - Stimulus: assert rst for 1 cycle while in PRESENT.
  - Required response: op_valid=0 and all operands 0 on the next cycle; s_ready=1.
REQ-037 Zero settle with a stray ack:
  - Stimulus: SETTLE_CYCLES=0, pulse op_ack during LOAD, load a full set with s_enc=0.
  - Required response: the stray op_ack is ignored; op_valid rises 1 cycle after word 19; enc=0.
